// File: rtl/copro_issue_queue.sv
// Coprocessor issue queue: mask/match decode with same-cycle accept/writeback
// response, in-order buffering, and release to execution after commit.
module copro_issue_queue #(
  parameter int unsigned NbInstr = 2,
  parameter int unsigned Depth   = 4,
  parameter int unsigned IdWidth = 4,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned OpWidth = 4,
  parameter logic [31:0]        InstrMask  [NbInstr] = '{default: 32'h0000_707F},
  parameter logic [31:0]        InstrMatch [NbInstr] = '{default: '0},
  parameter logic [OpWidth-1:0] InstrOp    [NbInstr] = '{default: '0},
  parameter logic               InstrWb    [NbInstr] = '{default: 1'b1}
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [31:0]                  issue_instr_i,
  input  logic [IdWidth-1:0]           issue_id_i,
  input  logic [XLEN-1:0]              issue_rs1_i,
  input  logic [XLEN-1:0]              issue_rs2_i,
  output logic                         issue_accept_o,
  output logic                         issue_writeback_o,
  input  logic                         commit_valid_i,
  input  logic [IdWidth-1:0]           commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         disp_valid_o,
  input  logic                         disp_ready_i,
  output logic [OpWidth-1:0]           disp_op_o,
  output logic [IdWidth-1:0]           disp_id_o,
  output logic [XLEN-1:0]              disp_rs1_o,
  output logic [XLEN-1:0]              disp_rs2_o,
  output logic                         disp_wb_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o,
  output logic                         multi_match_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth+1);

  logic [Depth-1:0]   valid_q, committed_q, killed_q;
  logic [PtrW-1:0]    head_q, tail_q;
  logic [OccW-1:0]    occ_q;
  logic               multi_q;

  logic [IdWidth-1:0] id_q  [Depth];
  logic [OpWidth-1:0] op_q  [Depth];
  logic [XLEN-1:0]    rs1_q [Depth];
  logic [XLEN-1:0]    rs2_q [Depth];
  logic [Depth-1:0]   wb_q;

  logic               hit_any, multi_hit, win_wb;
  logic [OpWidth-1:0] win_op;
  logic               full, handshake, push, pop, head_live, bypass;

  // Lowest-index hit wins; any further hit flags a multi-match.
  always_comb begin
    hit_any   = 1'b0;
    multi_hit = 1'b0;
    win_op    = '0;
    win_wb    = 1'b0;
    for (int unsigned i = 0; i < NbInstr; i++) begin
      if ((issue_instr_i & InstrMask[i]) == InstrMatch[i]) begin
        if (hit_any) begin
          multi_hit = 1'b1;
        end else begin
          win_op = InstrOp[i];
          win_wb = InstrWb[i];
        end
        hit_any = 1'b1;
      end
    end
  end

  assign issue_accept_o    = issue_valid_i & hit_any;
  assign issue_writeback_o = issue_accept_o & win_wb;

  assign full          = (occ_q == OccW'(Depth));
  assign issue_ready_o = !full & !flush_i;
  assign handshake     = issue_valid_i & issue_ready_o;
  assign push          = handshake & hit_any;
  assign bypass        = commit_valid_i & (commit_id_i == issue_id_i);

  assign head_live    = valid_q[head_q] & committed_q[head_q];
  assign disp_valid_o = head_live & !killed_q[head_q];
  // Killed heads drain on their own, one per cycle, without a dispatch.
  assign pop          = !flush_i & head_live & (killed_q[head_q] | disp_ready_i);

  assign disp_op_o     = op_q[head_q];
  assign disp_id_o     = id_q[head_q];
  assign disp_rs1_o    = rs1_q[head_q];
  assign disp_rs2_o    = rs2_q[head_q];
  assign disp_wb_o     = wb_q[head_q];
  assign occupancy_o   = occ_q;
  assign multi_match_o = multi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      multi_q     <= 1'b0;
    end else if (flush_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (commit_valid_i && valid_q[i] && !committed_q[i] && id_q[i] == commit_id_i) begin
          committed_q[i] <= 1'b1;
          killed_q[i]    <= commit_kill_i;
        end
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      // Tail slot is never valid when pushing, so the commit loop cannot collide with it.
      if (push) begin
        valid_q[tail_q]     <= 1'b1;
        committed_q[tail_q] <= bypass;
        killed_q[tail_q]    <= bypass & commit_kill_i;
        tail_q              <= tail_q + PtrW'(1);
      end
      occ_q <= occ_q + OccW'(push) - OccW'(pop);
      if (handshake && multi_hit) multi_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      id_q[tail_q]  <= issue_id_i;
      op_q[tail_q]  <= win_op;
      rs1_q[tail_q] <= issue_rs1_i;
      rs2_q[tail_q] <= issue_rs2_i;
      wb_q[tail_q]  <= win_wb;
    end
  end

endmodule

// File: tb/tb_copro_issue_queue.sv
// Bench for copro_issue_queue: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_copro_issue_queue;

  localparam logic [31:0] MASK  [3] = '{32'h0000_707F, 32'h0000_007F, 32'h0000_707F};
  localparam logic [31:0] MATCH [3] = '{32'h0000_100B, 32'h0000_002B, 32'h0000_202B};
  localparam logic [3:0]  OP    [3] = '{4'd3, 4'd5, 4'd9};
  localparam logic        WB    [3] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        iv = 1'b0, ready, accept, wb;
  logic [31:0] instr = '0;
  logic [3:0]  id = '0, cid = '0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic        cv = 1'b0, kill = 1'b0, dr = 1'b0;
  logic        dv, dwb, multi;
  logic [3:0]  dop, did;
  logic [63:0] drs1, drs2;
  logic [2:0]  occ;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  id;
    logic [3:0]  op;
    logic [63:0] rs1, rs2;
    logic        wb, c, k;
  } ent_t;
  ent_t q[$];
  logic m_multi = 1'b0;

  always #5 clk = ~clk;

  copro_issue_queue #(
    .NbInstr(3), .Depth(4), .IdWidth(4), .XLEN(64), .OpWidth(4),
    .InstrMask(MASK), .InstrMatch(MATCH), .InstrOp(OP), .InstrWb(WB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(iv), .issue_ready_o(ready), .issue_instr_i(instr),
    .issue_id_i(id), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_accept_o(accept), .issue_writeback_o(wb),
    .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(kill),
    .disp_valid_o(dv), .disp_ready_i(dr), .disp_op_o(dop), .disp_id_o(did),
    .disp_rs1_o(drs1), .disp_rs2_o(drs2), .disp_wb_o(dwb),
    .occupancy_o(occ), .multi_match_o(multi)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational/registered outputs mid-cycle, advance model at the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [3:0] i_id,
                       input logic c_v, input logic [3:0] c_id, input logic k,
                       input logic rdy, input logic fl);
    int nh;
    logic [3:0] wop;
    logic wwb, rdy_e, dv_e, pop;
    ent_t e;
    iv = v; instr = ins; id = i_id; cv = c_v; cid = c_id; kill = k; dr = rdy; flush = fl;
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
    nh = 0; wop = '0; wwb = 1'b0;
    for (int i = 0; i < 3; i++)
      if ((ins & MASK[i]) == MATCH[i]) begin
        if (nh == 0) begin wop = OP[i]; wwb = WB[i]; end
        nh++;
      end
    rdy_e = (q.size() < 4) && !fl;
    dv_e  = (q.size() > 0) && q[0].c && !q[0].k;
    @(negedge clk);
    chk("accept", accept, v && nh > 0);
    chk("writeback", wb, v && nh > 0 && wwb);
    chk("ready", ready, rdy_e);
    chk("occupancy", occ, q.size());
    chk("disp_valid", dv, dv_e);
    chk("multi_match", multi, m_multi);
    if (dv_e) begin
      chk("disp_id", did, q[0].id);
      chk("disp_op", dop, q[0].op);
      chk("disp_wb", dwb, q[0].wb);
      chk("disp_rs1", drs1, q[0].rs1);
      chk("disp_rs2", drs2, q[0].rs2);
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      pop = (q.size() > 0) && q[0].c && (q[0].k || rdy);
      if (c_v)
        foreach (q[j])
          if (!q[j].c && q[j].id == c_id) begin q[j].c = 1'b1; q[j].k = k; end
      if (pop) void'(q.pop_front());
      if (v && rdy_e && nh > 0) begin
        e.id = i_id; e.op = wop; e.rs1 = rs1; e.rs2 = rs2; e.wb = wwb;
        e.c = c_v && (c_id == i_id);
        e.k = e.c && k;
        q.push_back(e);
      end
      if (v && rdy_e && nh > 1) m_multi = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 4'd0, 1'b0, 4'd0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [31:0] pick;
    logic [3:0]  cpick;
    #2;
    chk("rst_occupancy", occ, 0);
    chk("rst_disp_valid", dv, 0);
    chk("rst_multi", multi, 0);
    chk("rst_ready", ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single op: issue id 2, commit next cycle, dispatch after
    cycle(1, 32'h0000_100B, 4'd2, 0, 4'd0, 0, 1, 0);
    cycle(0, 32'h0, 4'd0, 1, 4'd2, 0, 1, 0);
    idle(1);
    idle(1);
    // no-hit instruction
    cycle(1, 32'h0000_0033, 4'd1, 0, 4'd0, 0, 1, 0);
    idle(1);
    // fill, out-of-order commit stalls behind uncommitted head
    for (int i = 0; i < 4; i++) cycle(1, 32'h0000_302B, 4'(i), 0, 4'd0, 0, 1, 0);
    cycle(1, 32'h0000_100B, 4'd9, 1, 4'd1, 0, 1, 0);
    idle(1);
    cycle(0, 32'h0, 4'd0, 1, 4'd0, 0, 1, 0);
    cycle(1, 32'h0000_302B, 4'd2, 1, 4'd2, 0, 1, 0);
    cycle(0, 32'h0, 4'd0, 1, 4'd3, 0, 1, 0);
    for (int i = 0; i < 4; i++) idle(1);
    // kill then commit
    cycle(1, 32'h0000_100B, 4'd5, 0, 4'd0, 0, 1, 0);
    cycle(1, 32'h0000_100B, 4'd6, 1, 4'd5, 1, 1, 0);
    cycle(0, 32'h0, 4'd0, 1, 4'd6, 0, 1, 0);
    idle(1); idle(1); idle(1);
    // same-cycle issue+commit, held without ready
    cycle(1, 32'h0000_100B, 4'd7, 1, 4'd7, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle(0);
    idle(1);
    // overlapping entries, sticky multi-match, flush
    cycle(1, 32'h0000_202B, 4'd8, 0, 4'd0, 0, 0, 0);
    cycle(1, 32'h0000_100B, 4'd9, 0, 4'd0, 0, 0, 0);
    cycle(1, 32'h0000_302B, 4'd10, 0, 4'd0, 0, 0, 0);
    cycle(1, 32'h0000_100B, 4'd11, 1, 4'd8, 0, 0, 1);
    idle(1);
    idle(1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: pick = 32'h0000_100B;
        1: pick = 32'h0000_302B;
        2: pick = 32'h0000_202B;
        3: pick = 32'h0000_0033;
        default: pick = $urandom;
      endcase
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        cpick = q[$urandom_range(0, q.size() - 1)].id;
      else
        cpick = 4'($urandom);
      cycle($urandom_range(0, 9) < 7, pick, 4'($urandom), $urandom_range(0, 2) == 0, cpick,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end

    // asynchronous reset with a populated queue
    cnt = 0;
    while (q.size() < 2 && cnt < 20) begin
      cycle(1, 32'h0000_100B, 4'(cnt), 0, 4'd0, 0, 0, 0);
      cnt++;
    end
    chk("prefill_occupancy", occ, q.size());
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_multi = 1'b0;
    chk("async_rst_occupancy", occ, 0);
    chk("async_rst_disp_valid", dv, 0);
    chk("async_rst_multi", multi, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 32'h0000_100B, 4'd3, 1, 4'd3, 0, 1, 0);
    idle(1);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
